// File: rtl/cv32e40p_tmr_breakage_monitor.sv
// Leaky-bucket breakage monitor downstream of a TMR voter: per-replica error counters, sticky broken flags, TMR/DMR/FAILED mode.
// Optional: define CV32E40P_BREAKAGE_CLEAR_EN to let clear_i also drop broken flags and return to TMR_OK.
module cv32e40p_tmr_breakage_monitor #(
  parameter int unsigned INCREMENT          = 1,
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_i,
  input  logic [2:0]             err_i,
  input  logic                   clear_i,
  output logic [2:0]             broken_o,
  output logic [1:0]             mode_o,
  output logic [1:0]             healthy_sel_o,
  output logic                   uncorrectable_o,
  output logic                   fault_o,
  output logic [3*COUNT_BIT-1:0] count_o
);

  typedef enum logic [1:0] {
    TMR_OK   = 2'b00,
    DEGRADED = 2'b01,
    FAILED   = 2'b10
  } mode_e;

  localparam int unsigned          CNT_MAX   = (1 << COUNT_BIT) - 1;
  localparam bit                   THR_REACH = (BREAKING_THRESHOLD <= CNT_MAX);
  localparam logic [INC_DEC_BIT-1:0] INC_OP  = INCREMENT[INC_DEC_BIT-1:0];
  localparam logic [INC_DEC_BIT-1:0] DEC_OP  = DECREMENT[INC_DEC_BIT-1:0];
  localparam logic [COUNT_BIT:0]   INC_EXT   = (COUNT_BIT+1)'(INC_OP);
  localparam logic [COUNT_BIT:0]   DEC_EXT   = (COUNT_BIT+1)'(DEC_OP);
  localparam logic [COUNT_BIT:0]   MAX_EXT   = (COUNT_BIT+1)'(CNT_MAX);
  localparam logic [COUNT_BIT-1:0] THR_V     = COUNT_BIT'(BREAKING_THRESHOLD);

  logic [COUNT_BIT-1:0] cnt_q [3];
  logic [COUNT_BIT-1:0] cnt_d [3];
  logic [2:0]           broken_q, broken_d;
  mode_e                mode_q, mode_d;
  logic [1:0]           sel_q, sel_d;
  logic                 unc_q, unc_d;
  logic [COUNT_BIT:0]   sum;
  logic [1:0]           n_broken;
  logic [2:0]           err_eff;

  assign err_eff = err_i & ~broken_q;

  always_comb begin
    sum      = '0;
    broken_d = broken_q;
    for (int unsigned k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      sum      = {1'b0, cnt_q[k]} + INC_EXT;
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (sample_i && !broken_q[k] && (mode_q != FAILED)) begin
        if (err_eff[k]) begin
          cnt_d[k] = (sum > MAX_EXT) ? MAX_EXT[COUNT_BIT-1:0] : sum[COUNT_BIT-1:0];
        end else begin
          cnt_d[k] = ({1'b0, cnt_q[k]} < DEC_EXT) ? '0 : cnt_q[k] - DEC_EXT[COUNT_BIT-1:0];
        end
      end
      if (THR_REACH && (cnt_d[k] >= THR_V)) broken_d[k] = 1'b1;
    end
`ifdef CV32E40P_BREAKAGE_CLEAR_EN
    if (clear_i) broken_d = '0;
`endif
  end

  // Mode follows the next broken vector so degraded selection lands in the same cycle as the flag.
  always_comb begin
    n_broken = 2'(broken_d[0]) + 2'(broken_d[1]) + 2'(broken_d[2]);
    mode_d   = mode_q;
    case (mode_q)
      TMR_OK: begin
        if (n_broken >= 2'd2)      mode_d = FAILED;
        else if (n_broken == 2'd1) mode_d = DEGRADED;
      end
      DEGRADED: if (n_broken >= 2'd2) mode_d = FAILED;
      FAILED:   mode_d = FAILED;
      default:  mode_d = FAILED;
    endcase
`ifdef CV32E40P_BREAKAGE_CLEAR_EN
    if (clear_i) mode_d = TMR_OK;
`endif
    sel_d = 2'd0;
    if (mode_d == DEGRADED) begin
      if (!broken_d[0])      sel_d = 2'd0;
      else if (!broken_d[1]) sel_d = 2'd1;
      else                   sel_d = 2'd2;
    end
    unc_d = 1'b0;
    if (sample_i) begin
      if (mode_q == TMR_OK)   unc_d = (err_i == 3'b111);
      if (mode_q == DEGRADED) unc_d = (err_eff == ~broken_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= '0;
      broken_q <= '0;
      mode_q   <= TMR_OK;
      sel_q    <= '0;
      unc_q    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
      broken_q <= broken_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      unc_q    <= unc_d;
    end
  end

  always_comb begin
    count_o = '0;
    for (int unsigned k = 0; k < 3; k++) count_o[k*COUNT_BIT +: COUNT_BIT] = cnt_q[k];
  end

  assign broken_o        = broken_q;
  assign mode_o          = mode_q;
  assign healthy_sel_o   = sel_q;
  assign uncorrectable_o = unc_q;
  assign fault_o         = (mode_q == FAILED);

endmodule

// File: doc/cv32e40p_tmr_breakage_monitor.md
Name: cv32e40p_tmr_breakage_monitor

Overview:
Per-submodule breakage monitor for the triplicated IF-stage blocks: program counter definition, prefetch buffer, IF FSM, IF pipeline, aligner and compressed decoder. It sits directly downstream of each replicated submodule's majority voter. Each cycle it consumes the voter's per-replica disagreement flags and keeps one leaky-bucket error counter per replica. It declares a replica broken when that replica's counter reaches the threshold, and drives the voter's degraded-mode selection and the core's permanent-fault indication.

Parameters:
INCREMENT, 1, added to a replica counter on a sampled error
DECREMENT, 1, subtracted from a replica counter on a sampled clean cycle
BREAKING_THRESHOLD, 3, counter value at or above which a replica is declared broken
COUNT_BIT, 8, width of each replica counter
INC_DEC_BIT, 2, width of INCREMENT/DECREMENT operands; both values must fit in this width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
sample_i  in  1  voter output valid this cycle; counters update only when high
err_i  in  3  bit k = replica k disagreed with voted result (TMR mode) or with its DMR partner
clear_i  in  1  synchronous clear of all counters
broken_o  out  3  sticky per-replica broken flags
mode_o  out  2  00 TMR_OK, 01 DEGRADED, 10 FAILED
healthy_sel_o  out  2  in DEGRADED: index of lowest-numbered healthy replica the voter forwards; else 0
uncorrectable_o  out  1  one-cycle pulse: sampled error with no valid majority
fault_o  out  1  permanent fault to controller; equals mode_o==FAILED
count_o  out  3*COUNT_BIT  replica counters, replica 0 in LSBs

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n. All registers use the same asynchronous reset.
- Reset values: all counters 0, broken_o=000, mode_o=TMR_OK, healthy_sel_o=0, uncorrectable_o=0, fault_o=0.
- Effective error for replica k = err_i[k] & ~broken_o[k]. Broken replicas are masked, and their counters freeze at the last value.
- Counter update, when sample_i=1 and the replica is not broken:
  - Error: cnt = min(cnt+INCREMENT, 2^COUNT_BIT-1). Use a COUNT_BIT+1-bit sum, so saturation holds with no wrap-around.
  - No error: cnt = max(cnt-DECREMENT, 0). Underflow clamps to 0.
- Counters hold when sample_i=0.
- broken_o[k] is set on the clock edge that registers a next counter value >= BREAKING_THRESHOLD. It becomes visible 1 cycle after the triggering sample and is sticky.
- If BREAKING_THRESHOLD > 2^COUNT_BIT-1, the threshold is unreachable and no replica is ever broken.
- clear_i=1 zeroes all counters next cycle and has priority over sample_i in the same cycle. Broken flags are unaffected unless the optional feature is enabled.
- Mode FSM, evaluated from the next broken vector:
  - TMR_OK to DEGRADED when exactly one replica is broken.
  - TMR_OK or DEGRADED to FAILED when two or more replicas are broken.
  - FAILED is absorbing until reset.
  - Simultaneous breakage of two replicas from TMR_OK goes directly to FAILED.
- healthy_sel_o is registered together with mode_o.
- uncorrectable_o pulses 1 cycle after the sample in either of these cases:
  - TMR_OK with err_i==111; all three counters still increment.
  - DEGRADED with both healthy err bits set (DMR mismatch); both healthy counters increment.
- In FAILED, counters freeze and uncorrectable_o is held 0.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of clk.

Optional Feature:
Macro CV32E40P_BREAKAGE_CLEAR_EN.
- Defined: clear_i also clears broken_o and returns mode_o to TMR_OK. This supports software-directed re-integration after scrubbing.
- Undefined: broken_o and mode_o are cleared only by rst_n; clear_i affects counters only.

Test Plan:
- Reset with clear_i=0, sample_i=0 -> all outputs 0, count_o=0, mode_o=00.
- err_i=001 on 3 consecutive samples (defaults) -> count0 steps 1,2,3; broken_o=001, mode_o=01, healthy_sel_o=1 one cycle after third sample; further err_i=001 leaves count0=3.
- Alternating err_i=010/000 for 10 samples -> count1 toggles 1,0; broken_o stays 000; then err_i=111 once -> uncorrectable_o pulses 1 cycle, count_o increments all three.
- COUNT_BIT=2, BREAKING_THRESHOLD=4: err_i=100 for 6 samples -> count2 saturates at 3, never broken, no wrap to 0.
- Replica 0 broken, then err_i=110 for 3 samples -> uncorrectable_o pulses on each sample, broken_o=111, mode_o=10, fault_o=1; clear_i then -> mode stays FAILED without macro and returns to 00 with macro.
- Counts mid-rise (count0=2), rst_n pulsed low between clock edges -> outputs 0 immediately; sample_i together with clear_i -> counters 0.
